// File: rtl/axi_core_master_if.sv
// axi_core_master_if: single-beat AXI4 master bus between core master and interconnect
interface axi_core_master_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     ARID_M;
  logic [ADDR_W-1:0]   ARADDR_M;
  logic [3:0]          ARLEN_M;
  logic [2:0]          ARSIZE_M;
  logic [1:0]          ARBURST_M;
  logic                ARVALID_M;
  logic                ARREADY_M;
  logic [ID_W-1:0]     RID_M;
  logic [DATA_W-1:0]   RDATA_M;
  logic [1:0]          RRESP_M;
  logic                RLAST_M;
  logic                RVALID_M;
  logic                RREADY_M;
  logic [ID_W-1:0]     AWID_M;
  logic [ADDR_W-1:0]   AWADDR_M;
  logic [3:0]          AWLEN_M;
  logic [2:0]          AWSIZE_M;
  logic [1:0]          AWBURST_M;
  logic                AWVALID_M;
  logic                AWREADY_M;
  logic [DATA_W-1:0]   WDATA_M;
  logic [DATA_W/8-1:0] WSTRB_M;
  logic                WLAST_M;
  logic                WVALID_M;
  logic                WREADY_M;
  logic [ID_W-1:0]     BID_M;
  logic [1:0]          BRESP_M;
  logic                BVALID_M;
  logic                BREADY_M;
  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
           AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
           WDATA_M, WSTRB_M, WLAST_M, WVALID_M, BREADY_M,
    input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
           AWREADY_M, WREADY_M, BID_M, BRESP_M, BVALID_M
  );
  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
           AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
           WDATA_M, WSTRB_M, WLAST_M, WVALID_M, BREADY_M,
    output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
           AWREADY_M, WREADY_M, BID_M, BRESP_M, BVALID_M
  );
endinterface

// File: rtl/axi_core_master.sv
// axi_core_master: turns one core memory port into single-beat AXI4 read/write transactions
module axi_core_master #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MASTER_ID = 0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_done,
  output logic                core_err,
  output logic                core_busy,
  axi_core_master_if.master   m
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR_DATA, WRESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                we_q, aw_done_q, w_done_q, done_q, err_q;
  logic                aw_hs, w_hs, rd_fin, wr_fin;
  logic                unused_ok;
  assign unused_ok = ^{m.RID_M, m.RLAST_M, m.BID_M, we_q};
  assign m.ARID_M    = ID_W'(MASTER_ID);
  assign m.AWID_M    = ID_W'(MASTER_ID);
  assign m.ARADDR_M  = addr_q;
  assign m.AWADDR_M  = addr_q;
  assign m.ARLEN_M   = 4'd0;
  assign m.AWLEN_M   = 4'd0;
  assign m.ARSIZE_M  = 3'b010;
  assign m.AWSIZE_M  = 3'b010;
  assign m.ARBURST_M = 2'b01;
  assign m.AWBURST_M = 2'b01;
  assign m.WDATA_M   = wdata_q;
  assign m.WSTRB_M   = wstrb_q;
  assign m.WLAST_M   = 1'b1;
  assign core_rdata  = rdata_q;
  assign core_done   = done_q;
  assign core_err    = err_q;
  assign core_busy   = state_q != IDLE;
  assign aw_hs  = m.AWVALID_M & m.AWREADY_M;
  assign w_hs   = m.WVALID_M & m.WREADY_M;
  assign rd_fin = (state_q == RDATA) & m.RVALID_M;
  assign wr_fin = (state_q == WRESP) & m.BVALID_M;
  // state register
  always_ff @(posedge ACLK) state_q <= ARESET ? IDLE : state_d;
  // next state and channel handshake outputs; each write VALID drops after its own handshake
  always_comb begin
    state_d     = state_q;
    m.ARVALID_M = state_q == RADDR;
    m.RREADY_M  = state_q == RDATA;
    m.AWVALID_M = (state_q == WADDR_DATA) & ~aw_done_q;
    m.WVALID_M  = (state_q == WADDR_DATA) & ~w_done_q;
    m.BREADY_M  = state_q == WRESP;
    case (state_q)
      IDLE:       state_d = core_req ? (core_we ? WADDR_DATA : RADDR) : IDLE;
      RADDR:      state_d = m.ARREADY_M ? RDATA : RADDR;
      RDATA:      state_d = m.RVALID_M ? IDLE : RDATA;
      WADDR_DATA: state_d = ((aw_done_q | aw_hs) & (w_done_q | w_hs)) ? WRESP : WADDR_DATA;
      WRESP:      state_d = m.BVALID_M ? IDLE : WRESP;
      default:    state_d = IDLE;
    endcase
  end
  // request capture, write-handshake flags and completion/result registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state_q == IDLE && core_req) begin
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
        wstrb_q <= core_wstrb;
        we_q    <= core_we;
      end
      aw_done_q <= (state_q == WADDR_DATA) & (state_d == WADDR_DATA) & (aw_done_q | aw_hs);
      w_done_q  <= (state_q == WADDR_DATA) & (state_d == WADDR_DATA) & (w_done_q | w_hs);
      done_q    <= rd_fin | wr_fin;
      if (rd_fin) begin
        rdata_q <= m.RDATA_M;
        err_q   <= m.RRESP_M != 2'b00;
      end
      if (wr_fin) err_q <= m.BRESP_M != 2'b00;
    end
  end
endmodule

// File: tb/tb_axi_core_master.sv
// tb_axi_core_master: scoreboard bench acting as core and zero/variable-wait AXI slave
module tb_axi_core_master;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_wstrb;
  logic        core_done, core_err, core_busy;
  int          vectors = 0;
  int          miscompares = 0;
  typedef struct {logic we; logic [31:0] rdata; logic err;} exp_t;
  exp_t        sb[$];
  axi_core_master_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m();
  axi_core_master #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MASTER_ID(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_rdata(core_rdata), .core_done(core_done), .core_err(core_err),
    .core_busy(core_busy), .m(m)
  );
  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic sb_wait_done();
    exp_t e;
    int n = 0;
    while (!core_done && n < 20) begin
      cyc();
      n++;
    end
    vectors++;
    if (core_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout got %b exp 1", core_done);
      return;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected_done got done exp no pending request");
      return;
    end
    e = sb.pop_front();
    if (core_err !== e.err) begin
      miscompares++;
      $display("FAIL sb_err got %b exp %b", core_err, e.err);
    end
    if (!e.we) begin
      vectors++;
      if (core_rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL sb_rdata got %h exp %h", core_rdata, e.rdata);
      end
    end
  endtask

  task automatic test_read_delay();
    cyc();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0100;
    sb.push_back('{we: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    cyc();
    core_req = 1'b0; core_addr = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (m.ARVALID_M !== 1'b1 || m.ARADDR_M !== 32'h0000_0100) begin
        miscompares++;
        $display("FAIL rd_ar_stable%0d got valid %b addr %h exp 1 00000100", i, m.ARVALID_M, m.ARADDR_M);
      end
      if (i == 2) m.ARREADY_M = 1'b1;
      cyc();
    end
    m.ARREADY_M = 1'b0;
    vectors++;
    if ({m.ARLEN_M, m.ARSIZE_M, m.ARBURST_M, m.ARID_M} !== {4'd0, 3'b010, 2'b01, 4'd0}) begin
      miscompares++;
      $display("FAIL rd_ar_consts got %h exp %h", {m.ARLEN_M, m.ARSIZE_M, m.ARBURST_M, m.ARID_M}, {4'd0, 3'b010, 2'b01, 4'd0});
    end
    vectors++;
    if (m.ARVALID_M !== 1'b0 || m.RREADY_M !== 1'b1 || core_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_rdata_phase got arvalid %b rready %b done %b exp 0 1 0", m.ARVALID_M, m.RREADY_M, core_done);
    end
    m.RVALID_M = 1'b1; m.RDATA_M = 32'hDEAD_BEEF; m.RRESP_M = 2'b00;
    cyc();
    m.RVALID_M = 1'b0; m.RDATA_M = '0;
    vectors++;
    if (core_busy !== 1'b0 || m.RREADY_M !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_idle got busy %b rready %b exp 0 0", core_busy, m.RREADY_M);
    end
    sb_wait_done();
    cyc();
    vectors++;
    if (core_done !== 1'b0 || core_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_done_pulse got done %b rdata %h exp 0 deadbeef", core_done, core_rdata);
    end
  endtask

  task automatic test_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0200;
    cyc();
    core_req = 1'b0;
    vectors++;
    if (m.ARVALID_M !== 1'b1 || core_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre got arvalid %b busy %b exp 1 1", m.ARVALID_M, core_busy);
    end
    ARESET = 1'b1;
    cyc();
    cyc();
    ARESET = 1'b0;
    vectors++;
    if ({m.ARVALID_M, m.RREADY_M, m.AWVALID_M, m.WVALID_M, m.BREADY_M, core_busy, core_done, core_err} !== 8'h00 || core_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_state got ctl %b rdata %h exp 00000000 00000000",
               {m.ARVALID_M, m.RREADY_M, m.AWVALID_M, m.WVALID_M, m.BREADY_M, core_busy, core_done, core_err}, core_rdata);
    end
    vectors++;
    if (m.ARADDR_M !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_addr got %h exp 00000000", m.ARADDR_M);
    end
  endtask

  task automatic test_write_w_first();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0001_0004;
    core_wdata = 32'h1234_5678; core_wstrb = 4'b0011;
    sb.push_back('{we: 1'b1, rdata: 32'h0, err: 1'b0});
    cyc();
    core_req = 1'b0; core_wdata = 32'h0; core_wstrb = 4'b1111;
    vectors++;
    if ({m.AWVALID_M, m.WVALID_M, m.WLAST_M, m.BREADY_M} !== 4'b1110 || m.WSTRB_M !== 4'b0011 ||
        m.WDATA_M !== 32'h1234_5678 || m.AWADDR_M !== 32'h0001_0004) begin
      miscompares++;
      $display("FAIL wr_issue got ctl %b strb %b data %h addr %h exp 1110 0011 12345678 00010004",
               {m.AWVALID_M, m.WVALID_M, m.WLAST_M, m.BREADY_M}, m.WSTRB_M, m.WDATA_M, m.AWADDR_M);
    end
    vectors++;
    if ({m.AWLEN_M, m.AWSIZE_M, m.AWBURST_M, m.AWID_M} !== {4'd0, 3'b010, 2'b01, 4'd0}) begin
      miscompares++;
      $display("FAIL wr_aw_consts got %h exp %h", {m.AWLEN_M, m.AWSIZE_M, m.AWBURST_M, m.AWID_M}, {4'd0, 3'b010, 2'b01, 4'd0});
    end
    m.WREADY_M = 1'b1;
    cyc();
    m.WREADY_M = 1'b0;
    vectors++;
    if ({m.AWVALID_M, m.WVALID_M, m.BREADY_M} !== 3'b100) begin
      miscompares++;
      $display("FAIL wr_w_first got aw/w/b %b exp 100", {m.AWVALID_M, m.WVALID_M, m.BREADY_M});
    end
    m.AWREADY_M = 1'b1;
    cyc();
    m.AWREADY_M = 1'b0;
    vectors++;
    if ({m.AWVALID_M, m.WVALID_M, m.BREADY_M, core_done} !== 4'b0010) begin
      miscompares++;
      $display("FAIL wr_bresp_phase got aw/w/b/done %b exp 0010", {m.AWVALID_M, m.WVALID_M, m.BREADY_M, core_done});
    end
    m.BVALID_M = 1'b1; m.BRESP_M = 2'b00;
    cyc();
    m.BVALID_M = 1'b0;
    sb_wait_done();
  endtask

  task automatic test_write_same();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0040;
    core_wdata = 32'hA5A5_5A5A; core_wstrb = 4'b1111;
    sb.push_back('{we: 1'b1, rdata: 32'h0, err: 1'b0});
    cyc();
    core_req = 1'b0;
    m.AWREADY_M = 1'b1; m.WREADY_M = 1'b1;
    cyc();
    m.AWREADY_M = 1'b0; m.WREADY_M = 1'b0;
    vectors++;
    if ({m.AWVALID_M, m.WVALID_M, m.BREADY_M} !== 3'b001) begin
      miscompares++;
      $display("FAIL wr_same got aw/w/b %b exp 001", {m.AWVALID_M, m.WVALID_M, m.BREADY_M});
    end
    m.BVALID_M = 1'b1; m.BRESP_M = 2'b00;
    cyc();
    m.BVALID_M = 1'b0;
    sb_wait_done();
  endtask

  task automatic test_read_err();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0300;
    sb.push_back('{we: 1'b0, rdata: 32'h0BAD_0BAD, err: 1'b1});
    cyc();
    core_req = 1'b0;
    m.ARREADY_M = 1'b1;
    cyc();
    m.ARREADY_M = 1'b0;
    m.RVALID_M = 1'b1; m.RDATA_M = 32'h0BAD_0BAD; m.RRESP_M = 2'b10;
    cyc();
    m.RVALID_M = 1'b0; m.RRESP_M = 2'b00;
    sb_wait_done();
    cyc();
    cyc();
    vectors++;
    if (core_err !== 1'b1 || core_done !== 1'b0) begin
      miscompares++;
      $display("FAIL err_hold got err %b done %b exp 1 0", core_err, core_done);
    end
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0000_0304;
    sb.push_back('{we: 1'b1, rdata: 32'h0, err: 1'b0});
    cyc();
    core_req = 1'b0;
    m.AWREADY_M = 1'b1; m.WREADY_M = 1'b1;
    cyc();
    m.AWREADY_M = 1'b0; m.WREADY_M = 1'b0;
    m.BVALID_M = 1'b1; m.BRESP_M = 2'b00;
    cyc();
    m.BVALID_M = 1'b0;
    sb_wait_done();
  endtask

  task automatic test_back_to_back();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0500;
    sb.push_back('{we: 1'b0, rdata: 32'hCAFE_F00D, err: 1'b0});
    sb.push_back('{we: 1'b1, rdata: 32'h0, err: 1'b1});
    cyc();
    m.ARREADY_M = 1'b1;
    cyc();
    m.ARREADY_M = 1'b0;
    m.RVALID_M = 1'b1; m.RDATA_M = 32'hCAFE_F00D; m.RRESP_M = 2'b00;
    cyc();
    m.RVALID_M = 1'b0;
    core_we = 1'b1; core_addr = 32'h0000_0504; core_wdata = 32'h0F0F_0F0F; core_wstrb = 4'b1100;
    sb_wait_done();
    cyc();
    core_req = 1'b0;
    vectors++;
    if ({m.AWVALID_M, m.WVALID_M, core_busy} !== 3'b111 || m.AWADDR_M !== 32'h0000_0504 || m.WSTRB_M !== 4'b1100) begin
      miscompares++;
      $display("FAIL b2b_accept got aw/w/busy %b addr %h strb %b exp 111 00000504 1100",
               {m.AWVALID_M, m.WVALID_M, core_busy}, m.AWADDR_M, m.WSTRB_M);
    end
    m.AWREADY_M = 1'b1;
    cyc();
    m.AWREADY_M = 1'b0;
    m.WREADY_M = 1'b1;
    cyc();
    m.WREADY_M = 1'b0;
    m.BVALID_M = 1'b1; m.BRESP_M = 2'b11;
    cyc();
    m.BVALID_M = 1'b0; m.BRESP_M = 2'b00;
    sb_wait_done();
  endtask

  initial begin
    ARESET = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
    m.ARREADY_M = 1'b0; m.RID_M = '0; m.RDATA_M = '0; m.RRESP_M = '0; m.RLAST_M = 1'b1; m.RVALID_M = 1'b0;
    m.AWREADY_M = 1'b0; m.WREADY_M = 1'b0; m.BID_M = '0; m.BRESP_M = '0; m.BVALID_M = 1'b0;
    cyc();
    cyc();
    ARESET = 1'b0;
    test_read_delay();
    test_reset();
    test_write_w_first();
    test_write_same();
    test_read_err();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
